elink_tx_arbiter: RTL and testbench

- Shares one eLink transmit channel between three emesh requesters: read-response (rr), write (wr) and read (rd).
- Sits between the core-side txrr/txwr/txrd channels and the single serializer-side tx channel.
- Registered output slot with wait back-pressure.
- Arbitration: rr has strict priority, wr and rd alternate round-robin, and a burst limit prevents starvation.
- enable input lets software quiesce the link.

---
 rtl/elink_pkg.sv | 41 ++++
 rtl/elink_arb_pick.sv | 73 +++++++
 rtl/elink_tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_elink_tx_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/elink_pkg.sv
// -----------------------------------------------------------------------------
// elink_pkg
// Shared definitions for the eLink transmit arbiter slice.
//   - Channel index constants used to address the per-channel request and
//     grant vectors (CH_RR, CH_WR, CH_RD).
//   - owner_t: 2-bit encoding of the channel that received the last grant.
//   - PW_DEFAULT: default emesh packet width.
//   - BURST_W: width of the burst counter (MAX_BURST may be 1..15).
//   - onehot_to_owner: converts a one-hot grant vector into an owner_t.
// -----------------------------------------------------------------------------
package elink_pkg;

  localparam int PW_DEFAULT = 104;

  localparam int CH_RR  = 0;
  localparam int CH_WR  = 1;
  localparam int CH_RD  = 2;
  localparam int NUM_CH = 3;

  localparam int BURST_W = 4;

  typedef enum logic [1:0] {
    OWN_RR = 2'd0,
    OWN_WR = 2'd1,
    OWN_RD = 2'd2
  } owner_t;

  // A grant vector with no bit set maps to OWN_RR; callers only use the
  // result when some grant is active.
  function automatic owner_t onehot_to_owner(input logic [NUM_CH-1:0] grant);
    owner_t owner;
    owner = OWN_RR;
    if (grant[CH_WR]) begin
      owner = OWN_WR;
    end else if (grant[CH_RD]) begin
      owner = OWN_RD;
    end
    return owner;
  endfunction

endpackage

// File: rtl/elink_arb_pick.sv
// -----------------------------------------------------------------------------
// elink_arb_pick
// Purely combinational winner selection for the eLink transmit arbiter.
//
// Ports:
//   access     in  [NUM_CH]   request bits, indexed by CH_RR/CH_WR/CH_RD
//   last_owner in  owner_t    channel that received the most recent grant
//   burst_cnt  in  [BURST_W]  consecutive contended grants to last_owner
//   rr_ptr     in  owner_t    preferred channel of the wr/rd pair (WR or RD)
//   grant      out [NUM_CH]   one-hot winner, all zero when nobody requests
//
// The winner is chosen from the "eligible" set: normally every requester,
// but once last_owner has used up its burst while someone else is waiting,
// last_owner is dropped from the set for this one decision. Inside the
// eligible set rr always wins, and wr/rd are split by rr_ptr.
// -----------------------------------------------------------------------------
module elink_arb_pick
  import elink_pkg::*;
#(
  parameter int MAX_BURST = 4
)
(
  input  logic [NUM_CH-1:0]  access,
  input  owner_t             last_owner,
  input  logic [BURST_W-1:0] burst_cnt,
  input  owner_t             rr_ptr,
  output logic [NUM_CH-1:0]  grant
);

  logic [NUM_CH-1:0] owner_mask;
  logic [NUM_CH-1:0] eligible;
  logic              others_req;
  logic              limit_hit;

  // Decode last_owner into a mask so it can be removed from the request set.
  always_comb begin
    owner_mask = '0;
    case (last_owner)
      OWN_WR:  owner_mask[CH_WR] = 1'b1;
      OWN_RD:  owner_mask[CH_RD] = 1'b1;
      default: owner_mask[CH_RR] = 1'b1;
    endcase
  end

  // The burst limit only bites when some other channel is actually waiting;
  // a lone requester is never excluded.
  always_comb begin
    others_req = |(access & ~owner_mask);
    limit_hit  = others_req && (burst_cnt >= BURST_W'(MAX_BURST));
    eligible   = limit_hit ? (access & ~owner_mask) : access;
  end

  // Strict rr priority, then the wr/rd pair resolved by rr_ptr when both
  // are eligible. With rr excluded this naturally falls back to wr/rd, and
  // with wr or rd excluded it naturally picks rr or the other of the pair.
  always_comb begin
    grant = '0;
    if (eligible[CH_RR]) begin
      grant[CH_RR] = 1'b1;
    end else if (eligible[CH_WR] && eligible[CH_RD]) begin
      if (rr_ptr == OWN_RD) begin
        grant[CH_RD] = 1'b1;
      end else begin
        grant[CH_WR] = 1'b1;
      end
    end else if (eligible[CH_WR]) begin
      grant[CH_WR] = 1'b1;
    end else if (eligible[CH_RD]) begin
      grant[CH_RD] = 1'b1;
    end
  end

endmodule

// File: rtl/elink_tx_arbiter.sv
// -----------------------------------------------------------------------------
// elink_tx_arbiter
// Shares one eLink transmit channel between the read-response (rr), write
// (wr) and read (rd) emesh requesters through a single registered output
// slot with wait back-pressure.
//
// Ports:
//   clkin       in   single clock
//   hard_reset  in   synchronous, active-high reset
//   enable      in   1 = accept new packets, 0 = only drain the held packet
//   rr_access   in   read-response request valid
//   rr_packet   in   [PW] read-response packet
//   rr_wait     out  1 = rr not accepted this cycle
//   wr_access   in   write request valid
//   wr_packet   in   [PW] write packet
//   wr_wait     out  1 = wr not accepted this cycle
//   rd_access   in   read request valid
//   rd_packet   in   [PW] read packet
//   rd_wait     out  1 = rd not accepted this cycle
//   tx_access   out  registered output valid
//   tx_packet   out  [PW] registered output packet
//   tx_wait     in   downstream back-pressure
//   idle        out  1 = slot empty and nothing requesting
//
// Parameters:
//   PW         packet width
//   MAX_BURST  consecutive contended grants allowed to one channel (1..15)
// -----------------------------------------------------------------------------
module elink_tx_arbiter
  import elink_pkg::*;
#(
  parameter int PW        = PW_DEFAULT,
  parameter int MAX_BURST = 4
)
(
  input  logic          clkin,
  input  logic          hard_reset,
  input  logic          enable,
  input  logic          rr_access,
  input  logic [PW-1:0] rr_packet,
  output logic          rr_wait,
  input  logic          wr_access,
  input  logic [PW-1:0] wr_packet,
  output logic          wr_wait,
  input  logic          rd_access,
  input  logic [PW-1:0] rd_packet,
  output logic          rd_wait,
  output logic          tx_access,
  output logic [PW-1:0] tx_packet,
  input  logic          tx_wait,
  output logic          idle
);

  logic [NUM_CH-1:0]  access;
  logic [NUM_CH-1:0]  pick_grant;
  logic [NUM_CH-1:0]  grant;
  logic               load;
  logic               any_grant;
  logic               others_new;
  logic [PW-1:0]      next_packet;
  owner_t             grant_owner;

  owner_t             last_owner;
  owner_t             rr_ptr;
  logic [BURST_W-1:0] burst_cnt;

  assign access[CH_RR] = rr_access;
  assign access[CH_WR] = wr_access;
  assign access[CH_RD] = rd_access;

  // The slot may take a new packet when it is empty or being emptied this
  // cycle. Reset is folded in so no requester sees an acceptance that the
  // reset would throw away.
  assign load = enable & ~hard_reset & (~tx_access | ~tx_wait);

  elink_arb_pick #(
    .MAX_BURST (MAX_BURST)
  ) u_pick (
    .access     (access),
    .last_owner (last_owner),
    .burst_cnt  (burst_cnt),
    .rr_ptr     (rr_ptr),
    .grant      (pick_grant)
  );

  // A pick only becomes a grant on a load cycle; the waits are the inverse
  // of the qualified grant so at most one requester is released per cycle.
  always_comb begin
    grant       = pick_grant & {NUM_CH{load}};
    any_grant   = |grant;
    others_new  = |(access & ~grant);
    grant_owner = onehot_to_owner(grant);
  end

  assign rr_wait = ~grant[CH_RR];
  assign wr_wait = ~grant[CH_WR];
  assign rd_wait = ~grant[CH_RD];

  assign idle = ~tx_access & ~(|access);

  // Select the packet of whichever channel is granted this cycle.
  always_comb begin
    next_packet = rr_packet;
    if (grant[CH_WR]) begin
      next_packet = wr_packet;
    end else if (grant[CH_RD]) begin
      next_packet = rd_packet;
    end
  end

  // Output slot: loads on a grant, empties when a load cycle finds nobody
  // requesting, and also empties when the link is quiesced and downstream
  // takes the held packet. Otherwise the packet is held under tx_wait.
  always_ff @(posedge clkin) begin
    if (hard_reset) begin
      tx_access <= 1'b0;
      tx_packet <= '0;
    end else if (load) begin
      tx_access <= any_grant;
      if (any_grant) begin
        tx_packet <= next_packet;
      end
    end else if (!tx_wait) begin
      tx_access <= 1'b0;
    end
  end

  // Arbitration history. burst_cnt counts back-to-back grants to the same
  // owner only while somebody else is waiting; an uncontended grant clears
  // it and a change of owner restarts it at one. rr_ptr flips to the other
  // member of the wr/rd pair whenever one of them is served.
  always_ff @(posedge clkin) begin
    if (hard_reset) begin
      last_owner <= OWN_RR;
      rr_ptr     <= OWN_WR;
      burst_cnt  <= '0;
    end else if (any_grant) begin
      last_owner <= grant_owner;
      if (!others_new) begin
        burst_cnt <= '0;
      end else if (grant_owner != last_owner) begin
        burst_cnt <= BURST_W'(1);
      end else if (burst_cnt != '1) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
      if (grant[CH_WR]) begin
        rr_ptr <= OWN_RD;
      end else if (grant[CH_RD]) begin
        rr_ptr <= OWN_WR;
      end
    end
  end

endmodule

// File: tb/tb_elink_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_elink_tx_arbiter
// Randomized bench for elink_tx_arbiter with a behavioural reference model
// and a packet scoreboard. Inputs change 1 time unit after the rising edge;
// everything is observed on the falling edge.
// -----------------------------------------------------------------------------
module tb_elink_tx_arbiter;

  localparam int PW        = 104;
  localparam int MAX_BURST = 4;

  logic          clkin      = 1'b0;
  logic          hard_reset = 1'b1;
  logic          enable     = 1'b1;
  logic          tx_wait    = 1'b0;
  logic [2:0]    acc        = 3'b000;
  logic [PW-1:0] pkt [3];
  logic          rr_wait;
  logic          wr_wait;
  logic          rd_wait;
  logic          tx_access;
  logic [PW-1:0] tx_packet;
  logic          idle;

  int checks   = 0;
  int failures = 0;

  int req_pct [3];
  int wait_pct   = 0;
  int dis_pct    = 0;
  int rst_permil = 0;

  logic [2:0] taken     = 3'b000;
  logic       was_reset = 1'b0;

  logic [PW-1:0] exp_q [$];

  int m_last   = 0;
  int m_streak = 0;
  int m_pref   = 1;
  bit m_full   = 1'b0;

  always #5 clkin = ~clkin;

  elink_tx_arbiter #(
    .PW        (PW),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clkin      (clkin),
    .hard_reset (hard_reset),
    .enable     (enable),
    .rr_access  (acc[0]),
    .rr_packet  (pkt[0]),
    .rr_wait    (rr_wait),
    .wr_access  (acc[1]),
    .wr_packet  (pkt[1]),
    .wr_wait    (wr_wait),
    .rd_access  (acc[2]),
    .rd_packet  (pkt[2]),
    .rd_wait    (rd_wait),
    .tx_access  (tx_access),
    .tx_packet  (tx_packet),
    .tx_wait    (tx_wait),
    .idle       (idle)
  );

  // Shared comparison helper used by the model, the monitor and the
  // directed sequences.
  task automatic checkOutput(input string name, input logic [PW-1:0] act,
                             input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] newPacket();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[PW-1:0];
  endfunction

  // Index of the single released requester, 3 when none or several.
  function automatic int grantIdx();
    int idx;
    case ({rd_wait, wr_wait, rr_wait})
      3'b110:  idx = 0;
      3'b101:  idx = 1;
      3'b011:  idx = 2;
      default: idx = 3;
    endcase
    return idx;
  endfunction

  // One clock of stimulus. Requesters hold access/packet until released by
  // their wait; after a reset cycle they drop whatever they were offering.
  task automatic applyStimulus(input bit force_rst);
    @(posedge clkin);
    #1;
    for (int c = 0; c < 3; c++) begin
      if (was_reset || taken[c]) begin
        acc[c] = 1'b0;
      end
      if (!acc[c] && (int'($urandom_range(99)) < req_pct[c])) begin
        acc[c] = 1'b1;
        pkt[c] = newPacket();
      end
    end
    tx_wait    = (int'($urandom_range(99)) < wait_pct);
    enable     = !(int'($urandom_range(99)) < dis_pct);
    hard_reset = force_rst || (int'($urandom_range(999)) < rst_permil);
    @(negedge clkin);
    taken     = acc & ~{rd_wait, wr_wait, rr_wait};
    was_reset = hard_reset;
  endtask

  // Reference model. Winner = first requesting channel in the order
  // rr, preferred-of-wr/rd, other-of-wr/rd, skipping the previous owner when
  // its contended streak reached MAX_BURST and someone else is asking.
  // Each expected grant pushes the requester's packet into the scoreboard.
  always @(negedge clkin) begin : ref_model
    int       order [3];
    int       banned;
    int       g;
    bit       others;
    bit       can_load;
    logic [2:0] exp_w;
    if (hard_reset) begin
      checkOutput("reset_waits", PW'({rd_wait, wr_wait, rr_wait}), PW'(3'b111));
      exp_q.delete();
      m_full   = 1'b0;
      m_last   = 0;
      m_streak = 0;
      m_pref   = 1;
    end else begin
      checkOutput("tx_access", PW'(tx_access), PW'(m_full));
      checkOutput("idle", PW'(idle), PW'(!m_full && (acc == 3'b000)));
      can_load = enable && (!m_full || !tx_wait);
      banned = -1;
      if (m_streak >= MAX_BURST) begin
        for (int c = 0; c < 3; c++) begin
          if (c != m_last && acc[c]) banned = m_last;
        end
      end
      order = '{0, m_pref, 3 - m_pref};
      g = -1;
      if (can_load) begin
        for (int i = 0; i < 3; i++) begin
          if (g < 0 && acc[order[i]] && order[i] != banned) g = order[i];
        end
      end
      exp_w = 3'b111;
      if (g >= 0) exp_w[g] = 1'b0;
      checkOutput("waits", PW'({rd_wait, wr_wait, rr_wait}), PW'(exp_w));
      if (g >= 0) begin
        exp_q.push_back(pkt[g]);
        others = 1'b0;
        for (int c = 0; c < 3; c++) begin
          if (c != g && acc[c]) others = 1'b1;
        end
        if (!others) m_streak = 0;
        else if (g != m_last) m_streak = 1;
        else m_streak++;
        m_last = g;
        if (g == 1) m_pref = 2;
        else if (g == 2) m_pref = 1;
      end
      if (can_load) m_full = (g >= 0);
      else if (!tx_wait) m_full = 1'b0;
    end
  end

  // Monitor: every packet the downstream side consumes must be the oldest
  // one the model expects.
  always @(negedge clkin) begin : monitor
    logic [PW-1:0] exp_pkt;
    if (!hard_reset && tx_access && !tx_wait) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL tx_packet actual=%0h expected=none time=%0t", tx_packet, $time);
      end else begin
        exp_pkt = exp_q.pop_front();
        checkOutput("tx_packet", tx_packet, exp_pkt);
      end
    end
  end

  initial begin
    int grant_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2};
    int alt_seq   [4]  = '{1, 2, 1, 2};

    for (int c = 0; c < 3; c++) begin
      pkt[c]     = '0;
      req_pct[c] = 0;
    end
    applyStimulus(1'b1);
    applyStimulus(1'b1);

    // General randomized traffic with back-pressure, quiesce and resets.
    req_pct    = '{40, 40, 40};
    wait_pct   = 30;
    dis_pct    = 10;
    rst_permil = 5;
    repeat (3000) applyStimulus(1'b0);

    // Long quiesce window while requests and back-pressure continue.
    req_pct    = '{60, 60, 60};
    wait_pct   = 50;
    dis_pct    = 100;
    rst_permil = 0;
    repeat (20) applyStimulus(1'b0);

    // Heavy contention to exercise the burst limit.
    req_pct  = '{90, 90, 90};
    wait_pct = 10;
    dis_pct  = 0;
    repeat (800) applyStimulus(1'b0);

    // Reset with a full slot and all channels requesting, then the fixed
    // contention order rr x4, wr, rr x4, rd.
    req_pct  = '{100, 100, 100};
    wait_pct = 0;
    repeat (5) applyStimulus(1'b0);
    checkOutput("slot_full_before_reset", PW'(tx_access), PW'(1'b1));
    applyStimulus(1'b1);
    checkOutput("reset_all_waits", PW'({rd_wait, wr_wait, rr_wait}), PW'(3'b111));
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0);
      if (i == 0) checkOutput("post_reset_tx_access", PW'(tx_access), PW'(1'b0));
      checkOutput($sformatf("contention_grant_%0d", i), PW'(grantIdx()), PW'(grant_seq[i]));
    end

    // wr/rd alternation with rr silent.
    req_pct = '{0, 100, 100};
    applyStimulus(1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0);
      checkOutput($sformatf("alternate_grant_%0d", i), PW'(grantIdx()), PW'(alt_seq[i]));
    end

    // Drain everything and confirm nothing was lost.
    req_pct = '{0, 0, 0};
    repeat (20) applyStimulus(1'b0);
    checkOutput("scoreboard_drained", PW'(exp_q.size()), PW'(0));
    checkOutput("idle_at_end", PW'(idle), PW'(1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
